// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_port_arbiter
//  Description : Three-port round-robin arbiter that serialises four-phase
//                req/ack requesters onto the single-word read/write
//                interface of the sdram controller. A watchdog aborts any
//                transaction the controller fails to acknowledge in time.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              sys_clk,
    input  logic              sys_rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,

    input  logic              p2_req,
    input  logic              p2_we,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [DATA_W-1:0] p2_wdata,
    output logic              p2_ack,

    output logic [DATA_W-1:0] rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_read_req,
    input  logic              mem_read_ack,
    output logic              mem_write_req,
    input  logic              mem_write_ack,

    output logic              busy,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            r_state,   w_state_nxt;
    logic [1:0]        r_rr,      w_rr_nxt;
    logic              r_we,      w_we_nxt;
    logic [15:0]       r_wdog,    w_wdog_nxt;
    logic [2:0]        r_ack,     w_ack_nxt;
    logic [DATA_W-1:0] r_rdata,   w_rdata_nxt;
    logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
    logic [DATA_W-1:0] r_wdata,   w_wdata_nxt;
    logic              r_rd_req,  w_rd_req_nxt;
    logic              r_wr_req,  w_wr_req_nxt;
    logic              r_busy,    w_busy_nxt;
    logic [1:0]        r_grant,   w_grant_nxt;
    logic              r_tout,    w_tout_nxt;

    // Per-port views so the grant index can select a requester directly.
    logic [2:0]        w_req;
    logic [2:0]        w_port_we;
    logic [ADDR_W-1:0] w_port_addr  [3];
    logic [DATA_W-1:0] w_port_wdata [3];

    assign w_req           = {p2_req, p1_req, p0_req};
    assign w_port_we       = {p2_we, p1_we, p0_we};
    assign w_port_addr[0]  = p0_addr;
    assign w_port_addr[1]  = p1_addr;
    assign w_port_addr[2]  = p2_addr;
    assign w_port_wdata[0] = p0_wdata;
    assign w_port_wdata[1] = p1_wdata;
    assign w_port_wdata[2] = p2_wdata;

    // Search order rr, rr+1, rr+2 (mod 3); rr never holds 3.
    logic [1:0] w_c0, w_c1, w_c2;
    assign w_c0 = r_rr;
    assign w_c1 = (r_rr == 2'd2) ? 2'd0 : r_rr + 2'd1;
    assign w_c2 = (r_rr == 2'd0) ? 2'd2 : r_rr - 2'd1;

    // A port whose ack is still high is finishing its handshake and is skipped.
    logic [2:0] w_avail;
    assign w_avail = w_req & ~r_ack;

    // Only the ack matching the issued transaction type is observed.
    logic w_mack;
    assign w_mack = r_we ? mem_write_ack : mem_read_ack;

    // Round-robin pick of the first available port.
    logic       w_found;
    logic [1:0] w_sel;
    logic [1:0] w_sel_inc;
    always_comb begin
        w_found = 1'b1;
        w_sel   = w_c0;
        if (w_avail[w_c0]) begin
            w_sel = w_c0;
        end else if (w_avail[w_c1]) begin
            w_sel = w_c1;
        end else if (w_avail[w_c2]) begin
            w_sel = w_c2;
        end else begin
            w_found = 1'b0;
        end
        w_sel_inc = (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
    end

    // Next-state and next-output computation; every output is registered.
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_nxt     = r_rr;
        w_we_nxt     = r_we;
        w_wdog_nxt   = r_wdog;
        w_ack_nxt    = r_ack;
        w_rdata_nxt  = r_rdata;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_rd_req_nxt = r_rd_req;
        w_wr_req_nxt = r_wr_req;
        w_grant_nxt  = r_grant;
        w_tout_nxt   = r_tout;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt  = w_sel;
                    w_rr_nxt     = w_sel_inc;
                    w_we_nxt     = w_port_we[w_sel];
                    w_addr_nxt   = w_port_addr[w_sel];
                    w_wdata_nxt  = w_port_wdata[w_sel];
                    w_rd_req_nxt = ~w_port_we[w_sel];
                    w_wr_req_nxt = w_port_we[w_sel];
                    w_wdog_nxt   = 16'd0;
                    w_state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A completing ack wins over a watchdog expiry in the same cycle.
                if (w_mack) begin
                    w_rd_req_nxt = 1'b0;
                    w_wr_req_nxt = 1'b0;
                    if (!r_we) begin
                        w_rdata_nxt = mem_data_out;
                    end
                    w_state_nxt = S_RELEASE;
                end else if (r_wdog == c_TIMEOUT) begin
                    w_rd_req_nxt = 1'b0;
                    w_wr_req_nxt = 1'b0;
                    w_tout_nxt   = 1'b1;
                    if (!r_we) begin
                        w_rdata_nxt = '0;
                    end
                    w_ack_nxt   = 3'b001 << r_grant;
                    w_state_nxt = S_DONE;
                end else begin
                    w_wdog_nxt = r_wdog + 16'd1;
                end
            end
            S_RELEASE: begin
                if (!w_mack) begin
                    w_ack_nxt   = 3'b001 << r_grant;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!w_req[r_grant]) begin
                    w_ack_nxt   = 3'b000;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and output registers with asynchronous reset to all-zero.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state  <= S_IDLE;
            r_rr     <= 2'd0;
            r_we     <= 1'b0;
            r_wdog   <= 16'd0;
            r_ack    <= 3'b000;
            r_rdata  <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_busy   <= 1'b0;
            r_grant  <= 2'd0;
            r_tout   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr     <= w_rr_nxt;
            r_we     <= w_we_nxt;
            r_wdog   <= w_wdog_nxt;
            r_ack    <= w_ack_nxt;
            r_rdata  <= w_rdata_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_rd_req <= w_rd_req_nxt;
            r_wr_req <= w_wr_req_nxt;
            r_busy   <= w_busy_nxt;
            r_grant  <= w_grant_nxt;
            r_tout   <= w_tout_nxt;
        end
    end

    assign p0_ack        = r_ack[0];
    assign p1_ack        = r_ack[1];
    assign p2_ack        = r_ack[2];
    assign rdata         = r_rdata;
    assign mem_address   = r_addr;
    assign mem_data_in   = r_wdata;
    assign mem_read_req  = r_rd_req;
    assign mem_write_req = r_wr_req;
    assign busy          = r_busy;
    assign grant         = r_grant;
    assign timeout_err   = r_tout;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_port_arbiter
//  Description : Self-checking bench for sdram_port_arbiter: fixed vectors,
//                multi-cycle sequences and randomized traffic compared with
//                a round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int TOUT   = 15;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic [2:0]        req     = 3'b000;
    logic [2:0]        we      = 3'b000;
    logic [ADDR_W-1:0] addr  [3];
    logic [DATA_W-1:0] wdata [3];
    logic [DATA_W-1:0] mem_data_out  = '0;
    logic              mem_read_ack  = 1'b0;
    logic              mem_write_ack = 1'b0;

    logic              p0_ack, p1_ack, p2_ack;
    logic [2:0]        pack;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_read_req, mem_write_req;
    logic              busy;
    logic [1:0]        grant;
    logic              timeout_err;

    assign pack = {p2_ack, p1_ack, p0_ack};

    sdram_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TOUT)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .p0_req       (req[0]),
        .p0_we        (we[0]),
        .p0_addr      (addr[0]),
        .p0_wdata     (wdata[0]),
        .p0_ack       (p0_ack),
        .p1_req       (req[1]),
        .p1_we        (we[1]),
        .p1_addr      (addr[1]),
        .p1_wdata     (wdata[1]),
        .p1_ack       (p1_ack),
        .p2_req       (req[2]),
        .p2_we        (we[2]),
        .p2_addr      (addr[2]),
        .p2_wdata     (wdata[2]),
        .p2_ack       (p2_ack),
        .rdata        (rdata),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_read_req (mem_read_req),
        .mem_read_ack (mem_read_ack),
        .mem_write_req(mem_write_req),
        .mem_write_ack(mem_write_ack),
        .busy         (busy),
        .grant        (grant),
        .timeout_err  (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: round-robin pointer, last read data, sticky error.
    int          m_rr    = 0;
    logic [15:0] m_rdata = '0;
    bit          m_tout  = 1'b0;

    typedef struct {
        int          port;
        bit          w;
        logic [23:0] a;
        logic [15:0] wd;
        logic [15:0] rd;
        int          lat;
        bit          mute;
        bit          noise;
        logic [15:0] exp_rdata;
        bit          exp_tout;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
    endtask

    // First requesting port in order rr, rr+1, rr+2 (mod 3).
    function automatic int pick(input logic [2:0] m, input int rr);
        for (int i = 0; i < 3; i++) begin
            int p;
            p = (rr + i) % 3;
            if (m[p]) return p;
        end
        return 0;
    endfunction

    task automatic do_reset();
        sys_rst       = 1'b1;
        req           = 3'b000;
        mem_read_ack  = 1'b0;
        mem_write_ack = 1'b0;
        repeat (2) step();
        sys_rst = 1'b0;
        m_rr    = 0;
        m_rdata = '0;
        m_tout  = 1'b0;
        step();
    endtask

    // Serve one transaction expected on port ep, acting as the controller.
    // lat: cycles after the first issue cycle before the ack is driven.
    // mute: never ack. noise: hold the non-matching ack high while waiting.
    // drop: other requesters that withdraw while this one is in flight.
    task automatic serve(input int ep, input int lat, input bit mute, input bit noise,
                         input logic [15:0] rd, input logic [2:0] drop, input string tag);
        int          n;
        bit          got;
        bit          rdop;
        logic [23:0] ea;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            if (mem_read_req || mem_write_req) got = 1'b1;
        end
        chk({tag, " issue_seen"}, 32'(got), 32'd1);
        if (!got) begin
            req[ep] = 1'b0;
            return;
        end
        rdop = ~we[ep];
        ea   = addr[ep];
        chk({tag, " grant"}, 32'(grant), 32'(ep));
        chk({tag, " mem_address"}, 32'(mem_address), 32'(addr[ep]));
        chk({tag, " mem_data_in"}, 32'(mem_data_in), 32'(wdata[ep]));
        chk({tag, " req_type"}, {30'd0, mem_write_req, mem_read_req}, {30'd0, ~rdop, rdop});
        chk({tag, " busy_issue"}, 32'(busy), 32'd1);
        // Post-grant changes to the requester's fields must be ignored.
        addr[ep]  = 24'($urandom);
        wdata[ep] = 16'($urandom);
        we[ep]    = ~we[ep];
        req       = req & ~drop;
        if (noise) begin
            if (rdop) mem_write_ack = 1'b1;
            else      mem_read_ack  = 1'b1;
        end
        n = 1;
        if (!mute) begin
            for (int i = 0; i < lat; i++) begin
                step();
                if ((rdop ? (mem_read_req && !mem_write_req) : (mem_write_req && !mem_read_req))
                    && mem_address == ea) n++;
            end
            mem_read_ack  = rdop;
            mem_write_ack = ~rdop;
            mem_data_out  = rd;
            step();
            chk({tag, " req_cycles"}, 32'(n), 32'(lat + 1));
            chk({tag, " req_dropped"}, {31'd0, mem_read_req | mem_write_req}, 32'd0);
            if (rdop) m_rdata = rd;
            chk({tag, " rdata_after_ack"}, 32'(rdata), 32'(m_rdata));
            chk({tag, " pack_release"}, 32'(pack), 32'd0);
            mem_read_ack  = 1'b0;
            mem_write_ack = 1'b0;
            mem_data_out  = 16'($urandom);
            step();
        end else begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                step();
                if (mem_read_req || mem_write_req) n++;
                else got = 1'b1;
            end
            chk({tag, " timeout_cycles"}, 32'(n), 32'(TOUT + 1));
            m_tout = 1'b1;
            if (rdop) m_rdata = '0;
            mem_read_ack  = 1'b0;
            mem_write_ack = 1'b0;
        end
        chk({tag, " pack_onehot"}, 32'(pack), 32'(3'b001 << ep));
        chk({tag, " rdata_done"}, 32'(rdata), 32'(m_rdata));
        chk({tag, " timeout_err"}, 32'(timeout_err), 32'(m_tout));
        req[ep] = 1'b0;
        step();
        chk({tag, " pack_cleared"}, 32'(pack), 32'd0);
        chk({tag, " busy_idle"}, 32'(busy), 32'd0);
        m_rr = (ep + 1) % 3;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        int          order_rr [6];
        int          order_ct [3];
        logic [2:0]  mask;
        logic [2:0]  dm;
        int          ep;
        bit          quiet;

        //            port w     addr        wdata     ctl_rd    lat mute noise exp_rdata exp_tout
        tbl[0] = '{1, 1'b0, 24'h000123, 16'h0000, 16'hBEEF, 5,  1'b0, 1'b1, 16'hBEEF, 1'b0};
        tbl[1] = '{0, 1'b1, 24'hFFFFFF, 16'h5A5A, 16'h1111, 2,  1'b0, 1'b0, 16'hBEEF, 1'b0};
        tbl[2] = '{2, 1'b0, 24'h00ABCD, 16'h0000, 16'h1234, 0,  1'b0, 1'b0, 16'h1234, 1'b0};
        tbl[3] = '{0, 1'b0, 24'h000001, 16'h0000, 16'hFFFF, 15, 1'b0, 1'b0, 16'hFFFF, 1'b0};
        tbl[4] = '{2, 1'b0, 24'h000ABC, 16'h0000, 16'h7777, 0,  1'b1, 1'b0, 16'h0000, 1'b1};
        tbl[5] = '{1, 1'b1, 24'h000007, 16'hA55A, 16'h2222, 1,  1'b0, 1'b1, 16'h0000, 1'b1};
        tbl[6] = '{1, 1'b0, 24'h800000, 16'h0000, 16'hC3C3, 3,  1'b0, 1'b0, 16'hC3C3, 1'b1};
        tbl[7] = '{2, 1'b1, 24'h123456, 16'h0F0F, 16'h3333, 0,  1'b1, 1'b0, 16'hC3C3, 1'b1};
        order_rr = '{0, 1, 2, 0, 1, 2};
        order_ct = '{1, 2, 1};

        for (int p = 0; p < 3; p++) begin
            addr[p]  = '0;
            wdata[p] = '0;
        end

        // Reset values.
        do_reset();
        chk("reset pack", 32'(pack), 32'd0);
        chk("reset rdata", 32'(rdata), 32'd0);
        chk("reset mem_address", 32'(mem_address), 32'd0);
        chk("reset mem_data_in", 32'(mem_data_in), 32'd0);
        chk("reset ctl_bits", {28'd0, mem_read_req, mem_write_req, busy, timeout_err}, 32'd0);
        chk("reset grant", 32'(grant), 32'd0);

        // Table of single-requester transactions.
        for (int v = 0; v < 8; v++) begin
            we[tbl[v].port]    = tbl[v].w;
            addr[tbl[v].port]  = tbl[v].a;
            wdata[tbl[v].port] = tbl[v].wd;
            req[tbl[v].port]   = 1'b1;
            serve(tbl[v].port, tbl[v].lat, tbl[v].mute, tbl[v].noise, tbl[v].rd, 3'b000,
                  $sformatf("vec%0d", v));
            chk($sformatf("vec%0d table_rdata", v), 32'(rdata), 32'(tbl[v].exp_rdata));
            chk($sformatf("vec%0d table_tout", v), 32'(timeout_err), 32'(tbl[v].exp_tout));
        end

        // Asynchronous reset while a write is being issued.
        we[0] = 1'b1; addr[0] = 24'h00F00D; wdata[0] = 16'hCAFE; req = 3'b001;
        quiet = 1'b1;
        for (int i = 0; i < 6 && quiet; i++) begin
            step();
            if (mem_write_req) quiet = 1'b0;
        end
        chk("midrst write_issued", 32'(quiet), 32'd0);
        #2 sys_rst = 1'b1;
        #1;
        chk("midrst pack", 32'(pack), 32'd0);
        chk("midrst rdata", 32'(rdata), 32'd0);
        chk("midrst mem_address", 32'(mem_address), 32'd0);
        chk("midrst mem_data_in", 32'(mem_data_in), 32'd0);
        chk("midrst ctl_bits", {28'd0, mem_read_req, mem_write_req, busy, timeout_err}, 32'd0);
        chk("midrst grant", 32'(grant), 32'd0);
        step();
        m_rr = 0; m_rdata = '0; m_tout = 1'b0;
        for (int p = 0; p < 3; p++) begin
            we[p] = 1'($urandom); addr[p] = 24'($urandom); wdata[p] = 16'($urandom);
        end
        req = 3'b111;
        sys_rst = 1'b0;

        // All three ports hold requests from reset and re-request after each ack.
        for (int k = 0; k < 6; k++) begin
            serve(order_rr[k], k + 1, 1'b0, 1'b0, 16'($urandom), 3'b000, $sformatf("rr%0d", k));
            req[order_rr[k]] = 1'b1;
        end
        req = 3'b000;
        repeat (4) step();

        // Contention of ports 1 and 2 after reset; port 0 withdraws unserved.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            we[p] = 1'b0; addr[p] = 24'(32'h10 * p + 5); wdata[p] = 16'(p);
        end
        req = 3'b110;
        serve(order_ct[0], 2, 1'b0, 1'b0, 16'hAAAA, 3'b000, "ct0");
        req[1] = 1'b1;
        req[0] = 1'b1;
        serve(order_ct[1], 2, 1'b0, 1'b0, 16'hBBBB, 3'b001, "ct1");
        serve(order_ct[2], 2, 1'b0, 1'b0, 16'hCCCC, 3'b000, "ct2");
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (busy || mem_read_req || mem_write_req) quiet = 1'b0;
        end
        chk("ct withdrawn_not_served", 32'(quiet), 32'd1);

        // Randomized traffic against the round-robin model.
        do_reset();
        for (int r = 0; r < 40; r++) begin
            mask = 3'($urandom_range(1, 7));
            for (int p = 0; p < 3; p++) begin
                we[p] = 1'($urandom); addr[p] = 24'($urandom); wdata[p] = 16'($urandom);
            end
            req = mask;
            while (mask != 3'b000) begin
                ep = pick(mask, m_rr);
                dm = 3'b000;
                if ($urandom_range(0, 5) == 0)
                    dm = mask & ~(3'b001 << ep) & 3'($urandom);
                serve(ep, int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) == 0), 16'($urandom), dm, $sformatf("rnd%0d", r));
                mask = mask & ~(3'b001 << ep) & ~dm;
            end
            repeat (int'($urandom_range(0, 2))) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
